// File: rtl/i2s_src_arbiter.sv
// i2s_src_arbiter
//   Shares one I2S playback path among N_SRC requesters. Round-robin grant,
//   1-entry stereo sample buffer, one write per sample-request pulse,
//   zero-fill on underrun, grant revocation after TIMEOUT consecutive
//   underruns, and PRIME zero writes after reset to pre-fill the CDC FIFO.
//
//   state | meaning
//   PRIME | writing PRIME zero samples after reset
//   IDLE  | no owner; zero-fill requests, pick next eligible source
//   OWN   | one source owns the path and feeds the buffer
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req[N_SRC]            per-source ownership request (level)
//   i_audio_l/r             packed per-source samples, source k at [k*DATA_BIT +: DATA_BIT]
//   i_valid / o_ready       per-source sample handshake
//   o_grant                 one-hot owner, zero when idle
//   i_data_ready            one-cycle sample request from the CDC block
//   o_audio_l/r, o_data_valid  sample write to the CDC block
//   o_underrun_cnt          saturating count of zero-filled samples while owned
module i2s_src_arbiter #(
  parameter int DATA_BIT = 16,
  parameter int N_SRC    = 4,
  parameter int TIMEOUT  = 8,
  parameter int PRIME    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_SRC-1:0]          i_req,
  input  logic [N_SRC*DATA_BIT-1:0] i_audio_l,
  input  logic [N_SRC*DATA_BIT-1:0] i_audio_r,
  input  logic [N_SRC-1:0]          i_valid,
  output logic [N_SRC-1:0]          o_ready,
  output logic [N_SRC-1:0]          o_grant,
  input  logic                      i_data_ready,
  output logic [DATA_BIT-1:0]       o_audio_l,
  output logic [DATA_BIT-1:0]       o_audio_r,
  output logic                      o_data_valid,
  output logic [15:0]               o_underrun_cnt
);

  localparam int IW = $clog2(N_SRC);

  typedef enum logic [1:0] {S_PRIME, S_IDLE, S_OWN} state_t;

  state_t              state;
  logic [3:0]          prime_cnt;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       g_idx;
  logic [N_SRC-1:0]    mask;
  logic [7:0]          cons_cnt;
  logic                buf_full;
  logic [DATA_BIT-1:0] buf_l;
  logic [DATA_BIT-1:0] buf_r;

  logic [N_SRC-1:0]    elig;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                xfer;
  logic                underrun_hit;
  logic                timeout_hit;
  logic                release_hit;
  logic [DATA_BIT-1:0] sel_l;
  logic [DATA_BIT-1:0] sel_r;

  assign elig = i_req & ~mask;

  // First eligible source at or after the round-robin pointer, wrapping.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int i = 0; i < N_SRC; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_SRC) j = j - N_SRC;
      if (!pick_found && elig[j]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

  // Grant is zero outside OWN, so ready is confined to the owner.
  assign o_ready      = buf_full ? '0 : o_grant;
  assign xfer         = |(i_valid & o_ready);
  assign sel_l        = i_audio_l[g_idx*DATA_BIT +: DATA_BIT];
  assign sel_r        = i_audio_r[g_idx*DATA_BIT +: DATA_BIT];
  assign underrun_hit = (state == S_OWN) && i_data_ready && !buf_full;
  assign timeout_hit  = underrun_hit && ((cons_cnt + 8'd1) == 8'(TIMEOUT));
  assign release_hit  = (state == S_OWN) && !i_req[g_idx];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= S_PRIME;
      prime_cnt      <= '0;
      rr_ptr         <= '0;
      g_idx          <= '0;
      mask           <= '0;
      cons_cnt       <= '0;
      buf_full       <= 1'b0;
      buf_l          <= '0;
      buf_r          <= '0;
      o_grant        <= '0;
      o_audio_l      <= '0;
      o_audio_r      <= '0;
      o_data_valid   <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      o_data_valid <= 1'b0;
      // A source's mask clears once its request is seen low.
      mask <= mask & i_req;
      case (state)
        S_PRIME: begin
          // Sample requests here are absorbed by the priming writes.
          if (PRIME == 0) begin
            state <= S_IDLE;
          end else begin
            o_data_valid <= 1'b1;
            o_audio_l    <= '0;
            o_audio_r    <= '0;
            prime_cnt    <= prime_cnt + 4'd1;
            if (prime_cnt == 4'(PRIME - 1)) state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (i_data_ready) begin
            o_data_valid <= 1'b1;
            o_audio_l    <= '0;
            o_audio_r    <= '0;
          end
          if (pick_found) begin
            o_grant  <= N_SRC'(1) << pick_idx;
            g_idx    <= pick_idx;
            cons_cnt <= '0;
            state    <= S_OWN;
          end
        end
        S_OWN: begin
          if (i_data_ready) begin
            o_data_valid <= 1'b1;
            if (buf_full) begin
              o_audio_l <= buf_l;
              o_audio_r <= buf_r;
              buf_full  <= 1'b0;
              cons_cnt  <= '0;
            end else begin
              o_audio_l <= '0;
              o_audio_r <= '0;
              cons_cnt  <= cons_cnt + 8'd1;
              if (o_underrun_cnt != 16'hFFFF) o_underrun_cnt <= o_underrun_cnt + 16'd1;
            end
          end
          // No bypass: a sample arriving with a coincident request is held.
          if (xfer) begin
            buf_l    <= sel_l;
            buf_r    <= sel_r;
            buf_full <= 1'b1;
          end
          if (release_hit || timeout_hit) begin
            o_grant  <= '0;
            buf_full <= 1'b0;
            rr_ptr   <= (g_idx == IW'(N_SRC - 1)) ? '0 : g_idx + 1'b1;
            state    <= S_IDLE;
            if (timeout_hit && i_req[g_idx]) mask[g_idx] <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_src_arbiter.sv
module tb_i2s_src_arbiter;
  localparam int DB = 16;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] req;
  logic [NS*DB-1:0] audio_l;
  logic [NS*DB-1:0] audio_r;
  logic [NS-1:0] valid;
  logic [NS-1:0] ready;
  logic [NS-1:0] grant;
  logic          data_ready;
  logic [DB-1:0] out_l;
  logic [DB-1:0] out_r;
  logic          data_valid;
  logic [15:0]   underrun_cnt;

  always #5 clk = ~clk;

  i2s_src_arbiter #(.DATA_BIT(DB), .N_SRC(NS), .TIMEOUT(8), .PRIME(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_audio_l(audio_l), .i_audio_r(audio_r),
    .i_valid(valid), .o_ready(ready), .o_grant(grant), .i_data_ready(data_ready),
    .o_audio_l(out_l), .o_audio_r(out_r), .o_data_valid(data_valid),
    .o_underrun_cnt(underrun_cnt)
  );

  logic [31:0] exp_q[$];
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe pops one expected sample.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got %h expected no write", {out_l, out_r});
        end else begin
          e = exp_q.pop_front();
          check("write_data", {out_l, out_r}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_dr(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({l, r});
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
  endtask

  task automatic set_src(input int k, input logic [15:0] l, input logic [15:0] r);
    audio_l[k*DB +: DB] = l;
    audio_r[k*DB +: DB] = r;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_ready"}, 32'(ready), 32'h0);
    check({tag, "_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_audio"}, {out_l, out_r}, 32'h0);
    check({tag, "_ucnt"}, 32'(underrun_cnt), 32'h0);
  endtask

  initial begin
    int owners[4];
    owners = '{0, 2, 3, 0};
    rst = 1'b1; req = '0; audio_l = '0; audio_r = '0; valid = '0; data_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst0");

    // Priming: two zero writes.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    rst = 1'b0;
    repeat (5) tick();

    // Idle zero-fill, no underrun counting.
    repeat (3) pulse_dr(16'h0, 16'h0);
    check("idle_ucnt", 32'(underrun_cnt), 32'h0);

    // Source 1 streams one sample.
    req = 4'b0010;
    tick();
    check("s1_grant", 32'(grant), 32'h2);
    check("s1_ready", 32'(ready), 32'h2);
    set_src(1, 16'h1234, 16'hABCD);
    valid[1] = 1'b1;
    tick();
    valid[1] = 1'b0;
    check("s1_full_ready", 32'(ready), 32'h0);
    pulse_dr(16'h1234, 16'hABCD);
    check("s1_ucnt", 32'(underrun_cnt), 32'h0);

    // Request coincides with first transfer into empty buffer.
    set_src(1, 16'h5555, 16'h6666);
    valid[1] = 1'b1;
    exp_q.push_back(32'h0);
    data_ready = 1'b1;
    tick();
    valid[1] = 1'b0;
    data_ready = 1'b0;
    tick();
    check("coinc_ucnt", 32'(underrun_cnt), 32'h1);
    pulse_dr(16'h5555, 16'h6666);
    check("coinc_ucnt2", 32'(underrun_cnt), 32'h1);

    // Reset mid-stream with a full buffer; stale sample must never appear.
    set_src(1, 16'h7777, 16'h8888);
    valid[1] = 1'b1;
    tick();
    valid[1] = 1'b0;
    check("pre_rst_ready", 32'(ready), 32'h0);
    rst = 1'b1;
    req = '0;
    tick();
    check_reset_vals("rst1");
    tick();
    rst = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    data_ready = 1'b1;  // absorbed by priming
    tick();
    data_ready = 1'b0;
    repeat (4) tick();

    // Round robin among 0, 2, 3.
    req = 4'b1101;
    tick();
    for (int o = 0; o < 4; o++) begin
      int k;
      k = owners[o];
      check("rr_grant", 32'(grant), 32'(1) << k);
      for (int s = 0; s < 3; s++) begin
        logic [15:0] l, r;
        l = 16'(16'h1000 * (k + 1) + s);
        r = 16'(16'h0F00 + 16 * k + s);
        set_src(k, l, r);
        valid[k] = 1'b1;
        check("rr_ready", 32'(ready), 32'(1) << k);
        tick();
        valid[k] = 1'b0;
        pulse_dr(l, r);
      end
      req[k] = 1'b0;
      tick();
      check("rr_idle_gap", 32'(grant), 32'h0);
      if (o == 3) req = '0;
      else req[k] = 1'b1;
      tick();
    end
    check("rr_ucnt", 32'(underrun_cnt), 32'h0);

    // Timeout of stalled owner 2.
    req = 4'b0100;
    tick();
    check("to_grant", 32'(grant), 32'h4);
    for (int i = 0; i < 7; i++) pulse_dr(16'h0, 16'h0);
    check("to_grant_held", 32'(grant), 32'h4);
    pulse_dr(16'h0, 16'h0);
    check("to_revoked", 32'(grant), 32'h0);
    check("to_ucnt", 32'(underrun_cnt), 32'd8);
    repeat (5) tick();
    check("to_masked", 32'(grant), 32'h0);
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    check("to_regrant", 32'(grant), 32'h4);
    req = '0;
    tick();
    check("final_release", 32'(grant), 32'h0);

    repeat (4) tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
